// File: rtl/plcp_framer.sv
// Transmit-side 802.11a PLCP framer: serializes preamble, SIGNAL, SERVICE, PSDU,
// data tail and pad into a single-bit stream with registered outputs.
module plcp_framer #(
  parameter int unsigned PREAMBLE_BITS = 96,
  parameter int unsigned SERVICE_BITS  = 16,
  parameter int unsigned TAIL_BITS     = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Rate,
  input  logic [11:0] Length,
  input  logic [7:0]  Data_in,
  input  logic        Data_valid,
  output logic        Data_ready,
  output logic        Output,
  output logic        Out_valid,
  output logic        Scramble_en,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam int unsigned SIG_BITS = 18 + TAIL_BITS;
  localparam logic [14:0] PRE_LAST = 15'(PREAMBLE_BITS - 1);
  localparam logic [14:0] SIG_LAST = 15'(SIG_BITS - 1);
  localparam logic [14:0] SRV_LAST = 15'(SERVICE_BITS - 1);
  localparam logic [14:0] TAIL_LAST = 15'(TAIL_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SIGNAL, S_SERVICE, S_PSDU, S_TAIL, S_PAD, S_FLUSH
  } state_t;

  function automatic logic [7:0] ndbps_of(input logic [3:0] r);
    case (r)
      4'b1101: return 8'd24;
      4'b1111: return 8'd36;
      4'b0101: return 8'd48;
      4'b0111: return 8'd72;
      4'b1001: return 8'd96;
      4'b1011: return 8'd144;
      4'b0001: return 8'd192;
      4'b0011: return 8'd216;
      default: return 8'd0;
    endcase
  endfunction

  state_t        state, state_n;
  logic [14:0]   cnt, cnt_n;
  logic [7:0]    dbps_cnt, dbps_n, dbps_inc, ndbps;
  logic [3:0]    rate_q;
  logic [11:0]   len_q;
  logic [11:0]   fetched;
  logic [7:0]    buf_q, sh_q;
  logic          buf_full;
  logic [14:0]   psdu_last;
  logic [SIG_BITS-1:0] sig;
  logic          out_n, ov_n, scr_n, done_n, err_n;
  logic          start_ok, load_byte, shift_byte;

  assign ndbps     = ndbps_of(rate_q);
  assign dbps_inc  = (dbps_cnt == ndbps - 8'd1) ? '0 : dbps_cnt + 8'd1;
  assign psdu_last = {len_q, 3'b000} - 15'd1;
  assign sig       = {rate_q, 1'b0, len_q, ^{rate_q, len_q}, {TAIL_BITS{1'b0}}};
  assign Data_ready = Busy & ~buf_full & (fetched < len_q);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dbps_n     = dbps_cnt;
    out_n      = 1'b0;
    ov_n       = 1'b0;
    scr_n      = 1'b0;
    done_n     = 1'b0;
    err_n      = Error;
    start_ok   = 1'b0;
    load_byte  = 1'b0;
    shift_byte = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (ndbps_of(Rate) != 8'd0 && Length != '0) begin
            err_n    = 1'b0;
            start_ok = 1'b1;
            state_n  = S_PREAMBLE;
            cnt_n    = '0;
            dbps_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        ov_n  = 1'b1;
        out_n = ~cnt[0];
        cnt_n = cnt + 15'd1;
        if (cnt == PRE_LAST) begin
          cnt_n   = '0;
          state_n = S_SIGNAL;
        end
      end
      S_SIGNAL: begin
        ov_n  = 1'b1;
        out_n = sig[5'(SIG_BITS - 1) - cnt[4:0]];
        cnt_n = cnt + 15'd1;
        if (cnt == SIG_LAST) begin
          cnt_n   = '0;
          state_n = S_SERVICE;
        end
      end
      S_SERVICE: begin
        ov_n   = 1'b1;
        scr_n  = 1'b1;
        dbps_n = dbps_inc;
        cnt_n  = cnt + 15'd1;
        if (cnt == SRV_LAST) begin
          cnt_n   = '0;
          state_n = S_PSDU;
        end
      end
      S_PSDU: begin
        // An empty buffer at a byte boundary aborts the frame without Done.
        if (cnt[2:0] == 3'd0 && !buf_full) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          ov_n   = 1'b1;
          scr_n  = 1'b1;
          dbps_n = dbps_inc;
          cnt_n  = cnt + 15'd1;
          if (cnt[2:0] == 3'd0) begin
            load_byte = 1'b1;
            out_n     = buf_q[0];
          end else begin
            shift_byte = 1'b1;
            out_n      = sh_q[0];
          end
          if (cnt == psdu_last) begin
            cnt_n   = '0;
            state_n = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        ov_n   = 1'b1;
        dbps_n = dbps_inc;
        cnt_n  = cnt + 15'd1;
        if (cnt == TAIL_LAST) begin
          cnt_n   = '0;
          state_n = (dbps_inc == '0) ? S_FLUSH : S_PAD;
        end
      end
      S_PAD: begin
        ov_n   = 1'b1;
        scr_n  = 1'b1;
        dbps_n = dbps_inc;
        if (dbps_inc == '0) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dbps_cnt    <= '0;
      rate_q      <= '0;
      len_q       <= '0;
      fetched     <= '0;
      buf_q       <= '0;
      buf_full    <= 1'b0;
      sh_q        <= '0;
      Output      <= 1'b0;
      Out_valid   <= 1'b0;
      Scramble_en <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      dbps_cnt    <= dbps_n;
      Output      <= out_n;
      Out_valid   <= ov_n;
      Scramble_en <= scr_n;
      Busy        <= (state_n != S_IDLE);
      Done        <= done_n;
      Error       <= err_n;
      if (start_ok) begin
        rate_q   <= Rate;
        len_q    <= Length;
        buf_full <= 1'b0;
        fetched  <= '0;
      end else if (Data_valid && Data_ready) begin
        buf_q    <= Data_in;
        buf_full <= 1'b1;
        fetched  <= fetched + 12'd1;
      end else if (load_byte) begin
        buf_full <= 1'b0;
      end
      if (load_byte)
        sh_q <= {1'b0, buf_q[7:1]};
      else if (shift_byte)
        sh_q <= {1'b0, sh_q[7:1]};
    end
  end

endmodule

// File: tb/tb_plcp_framer.sv
// Self-checking bench for plcp_framer: a frame-level model builds the expected
// bit stream per frame and a monitor compares every cycle of the frame window.
module tb_plcp_framer;

  logic        Clock = 1'b0;
  logic        Reset, Start, Data_valid;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic [7:0]  Data_in;
  logic        Data_ready, Output, Out_valid, Scramble_en, Busy, Done, Error;

  plcp_framer #(.PREAMBLE_BITS(96), .SERVICE_BITS(16), .TAIL_BITS(6)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Rate(Rate), .Length(Length),
    .Data_in(Data_in), .Data_valid(Data_valid), .Data_ready(Data_ready),
    .Output(Output), .Out_valid(Out_valid), .Scramble_en(Scramble_en),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  bit   exp_bit [0:2047];
  bit   exp_scr [0:2047];
  int   mon_F, mon_i;
  bit   mon_under, mon_en, mon_done;
  int   ov_cnt, scr_cnt;
  logic [23:0] sig_cap;
  logic [7:0]  psdu_cap;
  logic [7:0]  feed_bytes [0:127];
  int   feed_idx, feed_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int ndbps(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  // Expected frame from the field rules; truncated after the supplied bytes on underrun.
  task automatic build_model(input logic [3:0] rate, input logic [11:0] len, input int nsup);
    int p = 0;
    int data_bits, pad;
    logic [23:0] s;
    logic [7:0] b;
    for (int k = 0; k < 96; k++) begin exp_bit[p] = (k % 2 == 0); exp_scr[p] = 0; p++; end
    s = {rate, 1'b0, len, 1'($countones({rate, len}) % 2), 6'b0};
    for (int k = 23; k >= 0; k--) begin exp_bit[p] = s[k]; exp_scr[p] = 0; p++; end
    for (int k = 0; k < 16; k++) begin exp_bit[p] = 0; exp_scr[p] = 1; p++; end
    for (int j = 0; j < int'(len); j++) begin
      b = feed_bytes[j];
      for (int k = 0; k < 8; k++) begin exp_bit[p] = b[k]; exp_scr[p] = 1; p++; end
    end
    for (int k = 0; k < 6; k++) begin exp_bit[p] = 0; exp_scr[p] = 0; p++; end
    data_bits = 16 + 8 * int'(len) + 6;
    pad = (ndbps(rate) - data_bits % ndbps(rate)) % ndbps(rate);
    for (int k = 0; k < pad; k++) begin exp_bit[p] = 0; exp_scr[p] = 1; p++; end
    mon_under = (nsup < int'(len));
    mon_F = mon_under ? (96 + 24 + 16 + 8 * nsup) : p;
  endtask

  task automatic monitor_loop();
    forever begin
      @(posedge Clock);
      #1;
      if (mon_en) begin
        int i = mon_i;
        bit in_frame = (i >= 1 && i <= mon_F);
        check("out_valid", Out_valid, in_frame);
        check("output", Output, in_frame ? exp_bit[i-1] : 1'b0);
        check("scramble_en", Scramble_en, in_frame ? exp_scr[i-1] : 1'b0);
        check("busy", Busy, i <= mon_F);
        check("done", Done, !mon_under && i == mon_F + 1);
        check("error", Error, mon_under && i == mon_F + 1);
        if (Out_valid) ov_cnt++;
        if (Scramble_en) scr_cnt++;
        if (i >= 97 && i <= 120) sig_cap = {sig_cap[22:0], Output};
        if (i >= 137 && i <= 144) psdu_cap = {psdu_cap[6:0], Output};
        mon_i++;
        if (mon_i > mon_F + 1) begin
          mon_en = 0;
          mon_done = 1;
        end
      end
    end
  endtask

  task automatic feeder();
    forever begin
      @(negedge Clock);
      if (feed_idx < feed_n) begin
        Data_valid = 1'b1;
        Data_in = feed_bytes[feed_idx];
        if (Data_ready) feed_idx++;
      end else begin
        Data_valid = 1'b0;
        Data_in = '0;
      end
    end
  endtask

  task automatic run_frame(input logic [3:0] rate, input logic [11:0] len, input int nsup);
    @(posedge Clock);
    #2;
    build_model(rate, len, nsup);
    feed_idx = 0;
    feed_n = nsup;
    ov_cnt = 0;
    scr_cnt = 0;
    @(negedge Clock);
    Rate = rate;
    Length = len;
    Start = 1'b1;
    mon_i = 0;
    mon_done = 0;
    mon_en = 1;
    @(negedge Clock);
    Start = 1'b0;
    for (int c = 0; c < 3000 && !mon_done; c++) @(negedge Clock);
    check("frame_timeout", mon_done, 1'b1);
    mon_en = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_output"}, Output, 1'b0);
    check({tag, "_out_valid"}, Out_valid, 1'b0);
    check({tag, "_scramble_en"}, Scramble_en, 1'b0);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_done"}, Done, 1'b0);
    check({tag, "_data_ready"}, Data_ready, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Rate = '0; Length = '0;
    Data_valid = 1'b0; Data_in = '0;
    feed_idx = 0; feed_n = 0; mon_en = 0; mon_done = 0; mon_i = 0; mon_F = 0;
    fork
      monitor_loop();
      feeder();
    join_none

    repeat (2) @(negedge Clock);
    check_idle_zero("reset");
    check("reset_error", Error, 1'b0);
    Reset = 1'b0;

    // Rate 1101, one byte 0x01: 168 bits, PSDU LSB first
    feed_bytes[0] = 8'h01;
    run_frame(4'b1101, 12'd1, 1);
    check("t1_frame_bits", ov_cnt, 168);
    check("t1_psdu_bits", psdu_cap, 8'h80);

    // SIGNAL field for Length 0x010
    for (int j = 0; j < 16; j++) feed_bytes[j] = 8'(j * 3 + 1);
    run_frame(4'b1101, 12'h010, 16);
    check("t2_signal", sig_cap, 24'hD00800);
    check("t2_frame_bits", ov_cnt, 288);

    // Rate 0011, 100 bytes: 42 pad bits
    for (int j = 0; j < 100; j++) feed_bytes[j] = 8'(j * 37 + 5);
    run_frame(4'b0011, 12'd100, 100);
    check("t3_frame_bits", ov_cnt, 984);
    check("t3_scramble_bits", scr_cnt, 858);

    // Invalid rate
    @(negedge Clock);
    Rate = 4'b0000; Length = 12'd5; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("bad_rate_error", Error, 1'b1);
      check_idle_zero("bad_rate");
      @(negedge Clock);
    end

    // Underrun at second byte boundary; valid start clears Error first
    for (int j = 0; j < 3; j++) feed_bytes[j] = 8'(8'h5A + j);
    run_frame(4'b1101, 12'd3, 1);
    check("t5_frame_bits", ov_cnt, 144);
    repeat (3) @(negedge Clock);
    check("t5_error_sticky", Error, 1'b1);
    check_idle_zero("t5_after");

    // Reset in the middle of the PSDU
    @(posedge Clock);
    #2;
    for (int j = 0; j < 4; j++) feed_bytes[j] = 8'(8'hC3 + j);
    feed_idx = 0;
    feed_n = 4;
    @(negedge Clock);
    Rate = 4'b1101; Length = 12'd4; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (140) @(negedge Clock);
    check("mid_out_valid", Out_valid, 1'b1);
    check("mid_scramble_en", Scramble_en, 1'b1);
    Reset = 1'b1;
    #1;
    check_idle_zero("mid_reset");
    check("mid_reset_error", Error, 1'b0);
    repeat (3) @(negedge Clock);
    check_idle_zero("mid_reset_hold");
    feed_n = 0;
    Reset = 1'b0;

    feed_bytes[0] = 8'h01;
    run_frame(4'b1101, 12'd1, 1);
    check("t6_frame_bits", ov_cnt, 168);
    check("t6_psdu_bits", psdu_cap, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
